// File: rtl/spw_pkg.sv
`default_nettype none
// spw_pkg : SpaceWire link state codes and timing defaults shared by link, rx and tx (rev 1.0)
package spw_pkg;

  typedef enum logic [2:0] {
    ST_ERROR_RESET = 3'd0,
    ST_ERROR_WAIT  = 3'd1,
    ST_READY       = 3'd2,
    ST_STARTED     = 3'd3,
    ST_CONNECTING  = 3'd4,
    ST_RUN         = 3'd5
  } link_state_t;

  localparam int DEFAULT_T_RESET_CYC = 320;
  localparam int DEFAULT_T_WAIT_CYC  = 640;

  // Counter width able to hold the larger of the two dwell loads.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spw_timer.sv
`default_nettype none
// spw_timer : loadable down-counter that holds at zero; expired while it reads zero (rev 1.0)
module spw_timer #(
  parameter int              WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/spw_link_fsm.sv
`default_nettype none
// spw_link_fsm : SpaceWire link initialisation state machine with registered enables (rev 1.0)
module spw_link_fsm
  import spw_pkg::*;
#(
  parameter int T_RESET_CYC = DEFAULT_T_RESET_CYC,
  parameter int T_WAIT_CYC  = DEFAULT_T_WAIT_CYC
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       link_start,
  input  logic       auto_start,
  input  logic       link_disable,
  input  logic       got_null,
  input  logic       got_fct,
  input  logic       got_nchar,
  input  logic       got_time,
  input  logic       err_disc,
  input  logic       err_par,
  input  logic       err_esc,
  input  logic       err_credit,
  output logic [2:0] state,
  output logic       rx_en,
  output logic       tx_en,
  output logic       fct_en,
  output logic       data_en,
  output logic       link_up,
  output logic       err_pulse
);

  localparam int             TW         = timer_width(T_RESET_CYC, T_WAIT_CYC);
  localparam logic [TW-1:0] RESET_LOAD = TW'(T_RESET_CYC - 1);
  localparam logic [TW-1:0] WAIT_LOAD  = TW'(T_WAIT_CYC - 1);

  link_state_t   state_q;
  link_state_t   state_d;
  logic          null_seen;
  logic          null_now;
  logic          err;
  logic          rx_event;
  logic          err_exit;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_expired;

  assign err      = err_disc | err_par | err_esc;
  assign rx_event = err | got_fct | got_nchar | got_time;
  // A NULL arriving this cycle counts as seen, so Ready/Started react without an extra cycle.
  assign null_now = null_seen | got_null;

  always_comb begin
    state_d  = state_q;
    err_exit = 1'b0;
    case (state_q)
      ST_ERROR_RESET: begin
        if (timer_expired) state_d = ST_ERROR_WAIT;
      end
      ST_ERROR_WAIT: begin
        if (rx_event) begin
          state_d  = ST_ERROR_RESET;
          err_exit = 1'b1;
        end else if (timer_expired) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (rx_event) begin
          state_d  = ST_ERROR_RESET;
          err_exit = 1'b1;
        end else if (!link_disable && (link_start || (auto_start && null_now))) begin
          state_d = ST_STARTED;
        end
      end
      ST_STARTED: begin
        if (rx_event || link_disable) begin
          state_d  = ST_ERROR_RESET;
          err_exit = 1'b1;
        end else if (timer_expired) begin
          state_d = ST_ERROR_RESET;
        end else if (null_now) begin
          state_d = ST_CONNECTING;
        end
      end
      ST_CONNECTING: begin
        if (err || got_nchar || got_time || link_disable) begin
          state_d  = ST_ERROR_RESET;
          err_exit = 1'b1;
        end else if (timer_expired) begin
          state_d = ST_ERROR_RESET;
        end else if (got_fct) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (err || err_credit || link_disable) begin
          state_d  = ST_ERROR_RESET;
          err_exit = 1'b1;
        end
      end
      default: state_d = ST_ERROR_RESET;
    endcase
  end

  // Reload the dwell timer on every state change.
  assign timer_load  = (state_d != state_q);
  assign timer_value = (state_d == ST_ERROR_RESET) ? RESET_LOAD : WAIT_LOAD;

  spw_timer #(
    .WIDTH       (TW),
    .RESET_VALUE (RESET_LOAD)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ERROR_RESET;
      null_seen <= 1'b0;
      rx_en     <= 1'b0;
      tx_en     <= 1'b0;
      fct_en    <= 1'b0;
      data_en   <= 1'b0;
      link_up   <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      null_seen <= (state_q == ST_ERROR_RESET) ? 1'b0 : (null_seen | got_null);
      rx_en     <= (state_d != ST_ERROR_RESET);
      tx_en     <= (state_d inside {ST_STARTED, ST_CONNECTING, ST_RUN});
      fct_en    <= (state_d inside {ST_CONNECTING, ST_RUN});
      data_en   <= (state_d == ST_RUN);
      link_up   <= (state_d == ST_RUN);
      err_pulse <= err_exit;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_spw_link_fsm.sv
`default_nettype none
// tb_spw_link_fsm : directed link scenarios plus random stimulus against a dwell-counting link model (rev 1.0)
module tb_spw_link_fsm;

  localparam int TR = 8;
  localparam int TW = 16;

  localparam logic [10:0] I_START  = 11'h001;
  localparam logic [10:0] I_AUTO   = 11'h002;
  localparam logic [10:0] I_DIS    = 11'h004;
  localparam logic [10:0] I_NULL   = 11'h008;
  localparam logic [10:0] I_FCT    = 11'h010;
  localparam logic [10:0] I_NCHAR  = 11'h020;
  localparam logic [10:0] I_TIME   = 11'h040;
  localparam logic [10:0] I_DISC   = 11'h080;
  localparam logic [10:0] I_PAR    = 11'h100;
  localparam logic [10:0] I_ESC    = 11'h200;
  localparam logic [10:0] I_CREDIT = 11'h400;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       link_start, auto_start, link_disable;
  logic       got_null, got_fct, got_nchar, got_time;
  logic       err_disc, err_par, err_esc, err_credit;
  logic [2:0] state;
  logic       rx_en, tx_en, fct_en, data_en, link_up, err_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state code, cycles spent in it, NULL-seen flag, expected pulse.
  int m_state = 0;
  int m_dwell = 0;
  bit m_null  = 1'b0;
  bit m_pulse = 1'b0;

  spw_link_fsm #(
    .T_RESET_CYC (TR),
    .T_WAIT_CYC  (TW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .link_start   (link_start),
    .auto_start   (auto_start),
    .link_disable (link_disable),
    .got_null     (got_null),
    .got_fct      (got_fct),
    .got_nchar    (got_nchar),
    .got_time     (got_time),
    .err_disc     (err_disc),
    .err_par      (err_par),
    .err_esc      (err_esc),
    .err_credit   (err_credit),
    .state        (state),
    .rx_en        (rx_en),
    .tx_en        (tx_en),
    .fct_en       (fct_en),
    .data_en      (data_en),
    .link_up      (link_up),
    .err_pulse    (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply(input logic [10:0] in);
    link_start   = in[0];
    auto_start   = in[1];
    link_disable = in[2];
    got_null     = in[3];
    got_fct      = in[4];
    got_nchar    = in[5];
    got_time     = in[6];
    err_disc     = in[7];
    err_par      = in[8];
    err_esc      = in[9];
    err_credit   = in[10];
  endtask

  task automatic check_outputs();
    logic [5:0] exp_v;
    exp_v = {m_state >= 1, m_state >= 3, m_state >= 4, m_state == 5, m_state == 5, m_pulse};
    check("state", state, m_state);
    check("enables", {rx_en, tx_en, fct_en, data_en, link_up, err_pulse}, exp_v);
  endtask

  // One clock of stimulus; the model decides the next state from the link rules.
  task automatic step(input logic [10:0] in);
    int nxt;
    bit pulse, tmo, err, ev;
    apply(in);
    err   = in[7] | in[8] | in[9];
    ev    = err | in[4] | in[5] | in[6];
    tmo   = (m_state == 0) ? (m_dwell == TR - 1) : (m_dwell == TW - 1);
    nxt   = m_state;
    pulse = 1'b0;
    case (m_state)
      0: if (tmo) nxt = 1;
      1: if (ev) begin nxt = 0; pulse = 1'b1; end
         else if (tmo) nxt = 2;
      2: if (ev) begin nxt = 0; pulse = 1'b1; end
         else if (!in[2] && (in[0] || (in[1] && (m_null || in[3])))) nxt = 3;
      3: if (ev || in[2]) begin nxt = 0; pulse = 1'b1; end
         else if (tmo) nxt = 0;
         else if (m_null || in[3]) nxt = 4;
      4: if (err || in[5] || in[6] || in[2]) begin nxt = 0; pulse = 1'b1; end
         else if (tmo) nxt = 0;
         else if (in[4]) nxt = 5;
      5: if (err || in[10] || in[2]) begin nxt = 0; pulse = 1'b1; end
      default: nxt = 0;
    endcase
    @(posedge clk);
    #1;
    m_null  = (m_state == 0) ? 1'b0 : (m_null | in[3]);
    m_dwell = (nxt == m_state) ? m_dwell + 1 : 0;
    m_state = nxt;
    m_pulse = pulse;
    check_outputs();
  endtask

  task automatic reset_dut();
    apply('0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    m_state = 0;
    m_dwell = 0;
    m_null  = 1'b0;
    m_pulse = 1'b0;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reset, link_start held, NULL 5 cycles into Started, FCT 3 cycles later.
  task automatic bring_up();
    logic [10:0] stim;
    reset_dut();
    for (int c = 1; c <= 33; c++) begin
      stim = I_START;
      if (c == 30) stim = stim | I_NULL;
      if (c == 33) stim = stim | I_FCT;
      step(stim);
      if (c == 7)  check("up_er_last", state, 0);
      if (c == 8)  check("up_ew_first", state, 1);
      if (c == 23) check("up_ew_last", state, 1);
      if (c == 24) check("up_ready", state, 2);
      if (c == 25) check("up_started", state, 3);
      if (c == 29) check("up_started_hold", state, 3);
      if (c == 30) check("up_connecting", state, 4);
      if (c == 33) check("up_run", state, 5);
    end
  endtask

  bit          start_lvl;
  bit          auto_lvl;
  logic [10:0] stim;

  initial begin
    apply('0);
    start_lvl = 1'b0;
    auto_lvl  = 1'b0;

    bring_up();
    check("a_link_up", link_up, 1);

    // Started without NULL times out silently.
    reset_dut();
    for (int c = 1; c <= 25; c++) step(I_START);
    check("b_started", state, 3);
    for (int c = 26; c <= 41; c++) begin
      step('0);
      if (c == 40) check("b_pre_tmo", state, 3);
      if (c == 41) begin
        check("b_tmo_state", state, 0);
        check("b_tmo_pulse", err_pulse, 0);
        check("b_tmo_tx", tx_en, 0);
      end
    end

    // FCT during ErrorWait is illegal.
    reset_dut();
    for (int c = 1; c <= 20; c++) begin
      step((c == 12) ? I_FCT : 11'h000);
      if (c == 8)  check("c_ew", state, 1);
      if (c == 12) begin
        check("c_er_state", state, 0);
        check("c_er_pulse", err_pulse, 1);
      end
      if (c == 13) check("c_pulse_once", err_pulse, 0);
      if (c == 19) check("c_er_last", state, 0);
      if (c == 20) check("c_ew_again", state, 1);
    end

    // Auto-start on NULL from Ready, and link_disable blocking it.
    reset_dut();
    for (int c = 1; c <= 24; c++) step('0);
    check("d_ready", state, 2);
    step(I_AUTO);
    check("d_wait_null", state, 2);
    step(I_AUTO | I_NULL);
    check("d_auto_start", state, 3);

    reset_dut();
    for (int c = 1; c <= 24; c++) step('0);
    step(I_AUTO | I_NULL | I_DIS);
    check("d_dis_hold", state, 2);
    step(I_AUTO | I_DIS);
    check("d_dis_hold2", state, 2);

    // Error beats a simultaneous FCT in Run.
    bring_up();
    step(I_PAR | I_FCT);
    check("e_state", state, 0);
    check("e_data_en", data_en, 0);
    check("e_pulse", err_pulse, 1);

    // Asynchronous reset out of Run, then full dwells.
    bring_up();
    reset_dut();
    check("f_async_state", state, 0);
    for (int c = 1; c <= 24; c++) begin
      step('0);
      if (c == 7)  check("f_er_last", state, 0);
      if (c == 8)  check("f_ew_first", state, 1);
      if (c == 23) check("f_ew_last", state, 1);
      if (c == 24) check("f_ready", state, 2);
    end

    // Random traffic.
    for (int r = 0; r < 6; r++) begin
      reset_dut();
      for (int k = 0; k < 700; k++) begin
        if ($urandom_range(0, 49) == 0) start_lvl = ~start_lvl;
        if ($urandom_range(0, 49) == 0) auto_lvl  = ~auto_lvl;
        stim     = '0;
        stim[0]  = start_lvl;
        stim[1]  = auto_lvl;
        stim[2]  = ($urandom_range(0, 149) == 0);
        stim[3]  = ($urandom_range(0, 5) == 0);
        stim[4]  = (m_state == 4) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
        stim[5]  = ($urandom_range(0, 249) == 0);
        stim[6]  = ($urandom_range(0, 249) == 0);
        stim[7]  = ($urandom_range(0, 249) == 0);
        stim[8]  = ($urandom_range(0, 249) == 0);
        stim[9]  = ($urandom_range(0, 249) == 0);
        stim[10] = ($urandom_range(0, 99) == 0);
        step(stim);
        if ($urandom_range(0, 999) == 0) reset_dut();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
